// File: rtl/fir_control_unit.sv
// Sequencer in front of FIR_datapath: coefficient load, sample streaming, result FIFO with backpressure.
// Define FIR_CTRL_OUT_COUNT_EN to add out_count_o (results popped since the last CLR).
module fir_control_unit #(
    parameter int MAX_TAPS       = 16,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [$clog2(MAX_TAPS)-1:0]   cfg_tap_count_i,
    input  logic                          cfg_start_i,
    input  logic                          cfg_stop_i,
    output logic                          cfg_err_o,
    output logic                          busy_o,
    input  logic                          s_coeff_valid_i,
    output logic                          s_coeff_ready_o,
    input  logic signed [31:0]            s_coeff_data_i,
    input  logic                          s_sample_valid_i,
    output logic                          s_sample_ready_o,
    input  logic signed [31:0]            s_sample_data_i,
    output logic                          m_out_valid_o,
    input  logic                          m_out_ready_i,
    output logic signed [31:0]            m_out_data_o,
    output logic                          dp_rstn_o,
    output logic [$clog2(MAX_TAPS)-1:0]   dp_tap_count_o,
    output logic                          dp_coeff_data_valid_o,
    output logic signed [31:0]            dp_coeff_data_o,
    output logic                          dp_input_data_valid_o,
    output logic signed [31:0]            dp_input_data_o,
    output logic                          dp_compute_o,
    input  logic signed [31:0]            dp_output_data_i,
`ifdef FIR_CTRL_OUT_COUNT_EN
    output logic [31:0]                   out_count_o,
`endif
    input  logic                          dp_output_data_valid_i
);

    // state  | meaning
    // IDLE   | no session, waiting for cfg_start
    // CLR    | one-cycle datapath reset
    // LOAD   | accepting dp_tap_count coefficients
    // RUN    | accepting samples while FIFO space can be reserved
    // DRAIN  | wait for in-flight result and empty FIFO
    localparam int TW = $clog2(MAX_TAPS);
    localparam int PW = $clog2(OUT_FIFO_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_CLR, ST_LOAD, ST_RUN, ST_DRAIN} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tap_q, tap_d;
    logic [TW-1:0]        coeff_cnt_q, coeff_cnt_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 inflight_q;
    logic signed [31:0]   mem_q [OUT_FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          count_q;

    logic coeff_hs, sample_hs, fifo_empty, fifo_full, push, pop, push_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (int'(count_q) == OUT_FIFO_DEPTH);
    assign push       = dp_output_data_valid_i;
    assign pop        = !fifo_empty && m_out_ready_i;
    assign push_ok    = push && (!fifo_full || pop);

    assign s_coeff_ready_o  = (state_q == ST_LOAD);
    // A slot is reserved for the result of the sample currently inside the datapath.
    assign s_sample_ready_o = (state_q == ST_RUN) &&
                              ((int'(count_q) + int'(inflight_q)) < OUT_FIFO_DEPTH);
    assign coeff_hs  = s_coeff_valid_i && s_coeff_ready_o;
    assign sample_hs = s_sample_valid_i && s_sample_ready_o;

    assign dp_coeff_data_valid_o = coeff_hs;
    assign dp_coeff_data_o       = coeff_hs ? s_coeff_data_i : '0;
    assign dp_input_data_valid_o = sample_hs;
    assign dp_compute_o          = sample_hs;
    assign dp_input_data_o       = sample_hs ? s_sample_data_i : '0;
    assign dp_rstn_o             = rstn_i && (state_q != ST_CLR);
    assign dp_tap_count_o        = tap_q;
    assign busy_o                = (state_q != ST_IDLE);
    assign cfg_err_o             = cfg_err_q;
    assign m_out_valid_o         = !fifo_empty;
    assign m_out_data_o          = fifo_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        coeff_cnt_d = coeff_cnt_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    if (cfg_tap_count_i == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        tap_d   = cfg_tap_count_i;
                        state_d = ST_CLR;
                    end
                end
            end
            ST_CLR: begin
                coeff_cnt_d = '0;
                state_d     = ST_LOAD;
            end
            ST_LOAD: begin
                if (coeff_hs) coeff_cnt_d = coeff_cnt_q + TW'(1);
                if (cfg_stop_i)                        state_d = ST_DRAIN;
                else if (coeff_hs && coeff_cnt_d == tap_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_stop_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight_q && fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            coeff_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            coeff_cnt_q <= coeff_cnt_d;
            cfg_err_q   <= cfg_err_d;
            inflight_q  <= sample_hs;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop)      count_q <= count_q + (PW+1)'(1);
            else if (pop && !push_ok) count_q <= count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= dp_output_data_i;
    end

`ifdef FIR_CTRL_OUT_COUNT_EN
    logic [31:0] out_count_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                out_count_q <= '0;
        else if (state_q == ST_CLR) out_count_q <= '0;
        else if (pop)               out_count_q <= out_count_q + 32'd1;
    end
    assign out_count_o = out_count_q;
`endif

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
                                    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fir_control_unit.sv
// Directed bench for fir_control_unit; also stands in for FIR_datapath (one-cycle result latency).
module tb_fir_control_unit;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, cfg_start, cfg_stop, cfg_err, busy;
    logic [TW-1:0] cfg_tap_count, dp_tap_count;
    logic s_coeff_valid, s_coeff_ready, s_sample_valid, s_sample_ready;
    logic signed [31:0] s_coeff_data, s_sample_data, m_out_data;
    logic m_out_valid, m_out_ready, dp_rstn, dp_coeff_data_valid, dp_input_data_valid, dp_compute;
    logic signed [31:0] dp_coeff_data, dp_input_data, dp_output_data;
    logic dp_output_data_valid;
`ifdef FIR_CTRL_OUT_COUNT_EN
    logic [31:0] out_count;
`endif

    logic dp_manual, man_ov, emu_ov;
    logic signed [31:0] man_od, emu_od;
    assign dp_output_data_valid = dp_manual ? man_ov : emu_ov;
    assign dp_output_data       = dp_manual ? man_od : emu_od;

    fir_control_unit #(.MAX_TAPS(16), .OUT_FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cfg_tap_count_i(cfg_tap_count), .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop),
        .cfg_err_o(cfg_err), .busy_o(busy),
        .s_coeff_valid_i(s_coeff_valid), .s_coeff_ready_o(s_coeff_ready), .s_coeff_data_i(s_coeff_data),
        .s_sample_valid_i(s_sample_valid), .s_sample_ready_o(s_sample_ready), .s_sample_data_i(s_sample_data),
        .m_out_valid_o(m_out_valid), .m_out_ready_i(m_out_ready), .m_out_data_o(m_out_data),
        .dp_rstn_o(dp_rstn), .dp_tap_count_o(dp_tap_count),
        .dp_coeff_data_valid_o(dp_coeff_data_valid), .dp_coeff_data_o(dp_coeff_data),
        .dp_input_data_valid_o(dp_input_data_valid), .dp_input_data_o(dp_input_data),
        .dp_compute_o(dp_compute), .dp_output_data_i(dp_output_data),
`ifdef FIR_CTRL_OUT_COUNT_EN
        .out_count_o(out_count),
`endif
        .dp_output_data_valid_i(dp_output_data_valid)
    );

    // Datapath stand-in: y[n] = sum c[k]*x[n-k], no result until more samples than taps.
    logic signed [31:0] coef [16];
    logic signed [31:0] hist [16];
    logic signed [31:0] acc, pend_y;
    logic pend;
    int cidx = 0, scnt = 0;
    always begin
        @(negedge clk);
        pend = 1'b0;
        if (!dp_rstn) begin
            cidx = 0; scnt = 0;
            for (int i = 0; i < 16; i++) hist[i] = '0;
        end else begin
            if (dp_coeff_data_valid && cidx < 16) begin coef[cidx] = dp_coeff_data; cidx++; end
            if (dp_input_data_valid) begin
                for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = dp_input_data;
                scnt++;
                if (scnt > cidx) begin
                    acc = '0;
                    for (int k = 0; k < cidx; k++) acc = acc + coef[k] * hist[k];
                    pend = 1'b1; pend_y = acc;
                end
            end
        end
        @(posedge clk); #1;
        emu_ov = pend; emu_od = pend_y;
    end

    int rp = 0, cp = 0;
    logic signed [31:0] got [$];
    always @(negedge clk) begin
        if (rstn && !dp_rstn) rp++;
        if (dp_coeff_data_valid) cp++;
        if (m_out_valid && m_out_ready) got.push_back(m_out_data);
    end

    int compared = 0, mismatched = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input bit is_coeff, input int v);
        int n = 0;
        if (is_coeff) begin s_coeff_valid = 1'b1; s_coeff_data = v; end
        else          begin s_sample_valid = 1'b1; s_sample_data = v; end
        @(negedge clk);
        while (!(is_coeff ? s_coeff_ready : s_sample_ready) && n < 100) begin @(negedge clk); n++; end
        check(is_coeff ? "coeff_hs_timeout" : "sample_hs_timeout", (n < 100), 1);
        cyc();
        if (is_coeff) s_coeff_valid = 1'b0; else s_sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin @(negedge clk); n++; end
        check(tag, busy, 0);
        cyc();
    endtask

    task automatic check_got(input string tag, input int idx, input int expv);
        logic signed [31:0] v;
        v = (idx < got.size()) ? got[idx] : 'x;
        check(tag, v, expv);
    endtask

    initial begin
        int base_rp, base_cp, gbase, n;
        int exp2 [5];
        int exp3 [6];
        exp2 = '{16, 22, 28, 34, 40};
        exp3 = '{16, 22, 28, 34, 1000, 40};
        rstn = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_tap_count = '0;
        s_coeff_valid = 1'b0; s_coeff_data = '0; s_sample_valid = 1'b0; s_sample_data = '0;
        m_out_ready = 1'b0; dp_manual = 1'b0; man_ov = 1'b0; man_od = '0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_dp_rstn", dp_rstn, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_m_out_valid", m_out_valid, 0);
        check("rst_coeff_ready", s_coeff_ready, 0);
        check("rst_tap_count", dp_tap_count, 0);
        cyc();
        rstn = 1'b1;

        // 1: zero tap count rejected
        base_rp = rp;
        cfg_tap_count = 4'd0; cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        @(negedge clk);
        check("t1_cfg_err_pulse", cfg_err, 1);
        check("t1_busy", busy, 0);
        cyc();
        @(negedge clk);
        check("t1_cfg_err_clear", cfg_err, 0);
        check("t1_no_dp_rstn", rp - base_rp, 0);
        cyc();

        // 2: tap=3, coeffs {1,2,3}, samples 1..8, consumer always ready
        base_cp = cp; gbase = got.size();
        m_out_ready = 1'b1; cfg_tap_count = 4'd3; cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        @(negedge clk);
        check("t2_clr_dp_rstn", dp_rstn, 0);
        check("t2_busy", busy, 1);
        check("t2_tap_latched", dp_tap_count, 3);
        cyc();
        @(negedge clk);
        check("t2_load_coeff_ready", s_coeff_ready, 1);
        check("t2_load_no_sample", s_sample_ready, 0);
        cyc();
        send(1, 1); send(1, 2); send(1, 3);
        @(negedge clk);
        check("t2_run_coeff_ready", s_coeff_ready, 0);
        check("t2_coeff_pulses", cp - base_cp, 3);
        cyc();
        for (int v = 1; v <= 8; v++) send(0, v);
        n = 0;
        while (got.size() - gbase < 5 && n < 50) begin cyc(); n++; end
        cyc();
        check("t2_result_count", got.size() - gbase, 5);
        for (int i = 0; i < 5; i++) check_got("t2_result", gbase + i, exp2[i]);
`ifdef FIR_CTRL_OUT_COUNT_EN
        @(negedge clk);
        check("t2_out_count", out_count, 5);
        cyc();
`endif
        cfg_stop = 1'b1;
        cyc();
        cfg_stop = 1'b0;
        wait_idle("t2_idle");

        // 3: consumer stalled, reservation throttles samples
        gbase = got.size();
        m_out_ready = 1'b0; cfg_tap_count = 4'd3; cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        send(1, 1); send(1, 2); send(1, 3);
        for (int v = 1; v <= 7; v++) send(0, v);
        s_sample_valid = 1'b1; s_sample_data = 8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_sample_ready_low", s_sample_ready, 0);
            cyc();
        end
        @(negedge clk);
        check("t3_out_valid", m_out_valid, 1);
        check("t3_head", m_out_data, 16);
        cyc();
        s_sample_valid = 1'b0;

        // 4: push and pop together while full
        dp_manual = 1'b1; man_ov = 1'b1; man_od = 1000; m_out_ready = 1'b1;
        @(negedge clk);
        check("t4_head_before", m_out_data, 16);
        check("t4_full_ready", s_sample_ready, 0);
        cyc();
        man_ov = 1'b0; m_out_ready = 1'b0;
        @(negedge clk);
        check("t4_head_after", m_out_data, 22);
        check("t4_still_full", s_sample_ready, 0);
        cyc();
        dp_manual = 1'b0; m_out_ready = 1'b1;
        send(0, 8);
        n = 0;
        while (got.size() - gbase < 6 && n < 50) begin cyc(); n++; end
        cyc();
        check("t3_result_count", got.size() - gbase, 6);
        for (int i = 0; i < 6; i++) check_got("t3_result", gbase + i, exp3[i]);
        cfg_stop = 1'b1;
        cyc();
        cfg_stop = 1'b0;
        wait_idle("t3_idle");

        // 5: stop with two results queued, drain, restart
        gbase = got.size();
        m_out_ready = 1'b0; cfg_tap_count = 4'd1; cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        send(1, 3);
        send(0, 1); send(0, 2); send(0, 3);
        cyc(); cyc();
        @(negedge clk);
        check("t5_queued_head", m_out_data, 6);
        cyc();
        cfg_stop = 1'b1;
        cyc();
        cfg_stop = 1'b0;
        base_rp = rp;
        s_sample_valid = 1'b1; s_sample_data = 4; cfg_tap_count = 4'd2; cfg_start = 1'b1;
        @(negedge clk);
        check("t5_drain_sample_ready", s_sample_ready, 0);
        check("t5_drain_busy", busy, 1);
        cyc();
        cfg_start = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        check("t5_drain_hold", busy, 1);
        check("t5_start_ignored", rp - base_rp, 0);
        check("t5_no_err", cfg_err, 0);
        cyc();
        s_sample_valid = 1'b0; m_out_ready = 1'b1;
        wait_idle("t5_idle");
        check("t5_drained_count", got.size() - gbase, 2);
        check_got("t5_first", gbase, 6);
        check_got("t5_second", gbase + 1, 9);
        base_rp = rp;
        cfg_tap_count = 4'd2; cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge clk);
        check("t5_restart_dp_rstn_pulse", rp - base_rp, 1);
        check("t5_restart_load", s_coeff_ready, 1);
        cyc();

        // 6: reset during LOAD
        send(1, 7);
        s_coeff_valid = 1'b1; s_coeff_data = 5;
        rstn = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_dp_rstn", dp_rstn, 0);
        check("t6_coeff_ready", s_coeff_ready, 0);
        check("t6_coeff_valid", dp_coeff_data_valid, 0);
        check("t6_coeff_data", dp_coeff_data, 0);
        check("t6_tap_count", dp_tap_count, 0);
        check("t6_m_out_valid", m_out_valid, 0);
`ifdef FIR_CTRL_OUT_COUNT_EN
        check("t6_out_count", out_count, 0);
`endif
        cyc();
        s_coeff_valid = 1'b0; rstn = 1'b1;
        @(negedge clk);
        check("t6_idle_after", busy, 0);
        check("t6_dp_rstn_release", dp_rstn, 1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
